// File: rtl/mole_pkg.sv
// Shared mole-game types, default sizing/timing and the popcount helper.
// Imported by the spawner, its per-hole timers, rng and the score logic.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PICK
    } state_e;

    localparam int NUM_HOLES_DEF      = 18;
    localparam int SPAWN_INTERVAL_DEF = 500;
    localparam int UP_TIME_DEF        = 2000;
    localparam int MAX_ACTIVE_DEF     = 3;
    localparam int MAX_RETRY_DEF      = 4;
    localparam int ACCEL_STEP_DEF     = 10;
    localparam int MIN_INTERVAL_DEF   = 100;

    localparam int POP_W = 64;

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mole_timer.sv
// Per-hole up-timer: holds a mole up for UP_TIME cycles after load.
// Clear beats load; expire_pulse marks the last visible cycle.
module mole_timer
    import mole_pkg::*;
#(
    parameter int UP_TIME = UP_TIME_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic up,
    output logic expire_pulse
);

    localparam int TW = $clog2(UP_TIME + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            up  <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            up  <= 1'b0;
        end else if (load) begin
            cnt <= TW'(UP_TIME);
            up  <= 1'b1;
        end else if (up) begin
            if (cnt == TW'(1)) begin
                cnt <= '0;
                up  <= 1'b0;
            end else begin
                cnt <= cnt - TW'(1);
            end
        end
    end

    assign expire_pulse = up && (cnt == TW'(1));

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: samples rng hole indices, runs per-hole up-timers, resolves hits.
// Define MOLE_SPAWN_ACCEL_EN to shorten the spawn interval as total hits grow.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int NUM_HOLES      = NUM_HOLES_DEF,
    parameter int SPAWN_INTERVAL = SPAWN_INTERVAL_DEF,
    parameter int UP_TIME        = UP_TIME_DEF,
    parameter int MAX_ACTIVE     = MAX_ACTIVE_DEF,
    parameter int MAX_RETRY      = MAX_RETRY_DEF,
    parameter int ACCEL_STEP     = ACCEL_STEP_DEF,
    parameter int MIN_INTERVAL   = MIN_INTERVAL_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [$clog2(NUM_HOLES)-1:0]   random_value,
    input  logic [NUM_HOLES-1:0]           hit_mask,
    output logic [NUM_HOLES-1:0]           mole_mask,
    output logic [$clog2(NUM_HOLES+1)-1:0] hit_count,
    output logic [$clog2(NUM_HOLES+1)-1:0] miss_count,
    output logic                           whiff_pulse
);

    localparam int RW  = $clog2(NUM_HOLES);
    localparam int CW  = $clog2(NUM_HOLES + 1);
    localparam int PW  = 1 << RW;
    localparam int IW  = $clog2(SPAWN_INTERVAL + 1);
    localparam int TRW = $clog2(MAX_RETRY + 1);

    localparam logic [RW:0]    HOLES_U    = (RW+1)'(NUM_HOLES);
    localparam logic [TRW-1:0] RETRY_LAST = TRW'(MAX_RETRY - 1);
    localparam logic [31:0]    ACT_U      = 32'(MAX_ACTIVE);
    localparam logic [31:0]    SPAN_U     = 32'(SPAWN_INTERVAL);
    localparam logic [31:0]    STEP_U     = 32'(ACCEL_STEP);
    localparam logic [31:0]    MIN_U      = 32'(MIN_INTERVAL);

    state_e               state;
    state_e               state_nx;
    logic [IW-1:0]        ivl_cnt;
    logic [IW-1:0]        ivl_len;
    logic [TRW-1:0]       retry;
    logic                 ivl_load;
    logic                 retry_clr;
    logic                 retry_inc;
    logic                 full;
    logic                 idx_ok;
    logic                 accept;
    logic [PW-1:0]        occ_pad;
    logic [NUM_HOLES-1:0] hit_v;
    logic [NUM_HOLES-1:0] miss_v;
    logic [NUM_HOLES-1:0] exp_v;
    logic [NUM_HOLES-1:0] load_v;
    logic [NUM_HOLES-1:0] clr_v;
    logic [31:0]          hits_w;

    // Zero hits always yields the base interval.
    function automatic logic [31:0] reload_len(input logic [31:0] hits);
        logic [31:0] dec;
        dec = STEP_U * hits;
        if (dec == '0) return SPAN_U;
        if (dec + MIN_U >= SPAN_U) return MIN_U;
        return SPAN_U - dec;
    endfunction

    assign occ_pad = PW'(mole_mask);
    assign full    = popcount(POP_W'(mole_mask)) >= ACT_U;
    assign idx_ok  = ({1'b0, random_value} < HOLES_U) && !occ_pad[random_value];
    assign accept  = enable && (state == PICK) && !full && idx_ok;
    assign ivl_len = IW'(reload_len(hits_w));

    assign hit_v  = enable ? (hit_mask & mole_mask) : '0;
    assign miss_v = exp_v & ~hit_v;
    assign clr_v  = enable ? hit_v : '1;

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
        assign load_v[i] = accept && (random_value == RW'(i));

        mole_timer #(
            .UP_TIME(UP_TIME)
        ) u_timer (
            .clk         (clk),
            .reset       (reset),
            .load        (load_v[i]),
            .clear       (clr_v[i]),
            .up          (mole_mask[i]),
            .expire_pulse(exp_v[i])
        );
    end

    always_comb begin
        state_nx  = state;
        ivl_load  = 1'b0;
        retry_clr = 1'b0;
        retry_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = WAIT;
                    ivl_load = 1'b1;
                end
            end
            WAIT: begin
                if (ivl_cnt == '0) state_nx = PICK;
            end
            PICK: begin
                if (full || idx_ok || retry == RETRY_LAST) begin
                    state_nx  = WAIT;
                    ivl_load  = 1'b1;
                    retry_clr = 1'b1;
                end else begin
                    retry_inc = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!enable) begin
            state_nx  = IDLE;
            ivl_load  = 1'b0;
            retry_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ivl_cnt <= '0;
            retry   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == IDLE) begin
                ivl_cnt <= '0;
            end else if (ivl_load) begin
                ivl_cnt <= ivl_len - IW'(1);
            end else if (state == WAIT && ivl_cnt != '0) begin
                ivl_cnt <= ivl_cnt - IW'(1);
            end
            if (retry_clr) begin
                retry <= '0;
            end else if (retry_inc) begin
                retry <= retry + TRW'(1);
            end
        end
    end

`ifdef MOLE_SPAWN_ACCEL_EN
    logic [IW-1:0] hits_total;
    logic [31:0]   hits_sum;

    assign hits_sum = 32'(hits_total) + popcount(POP_W'(hit_v));
    assign hits_w   = 32'(hits_total);

    // Saturating at all-ones is enough: past SPAWN_INTERVAL hits the floor applies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_total <= '0;
        end else if (state == IDLE) begin
            hits_total <= '0;
        end else if (hits_sum > 32'({IW{1'b1}})) begin
            hits_total <= '1;
        end else begin
            hits_total <= IW'(hits_sum);
        end
    end
`else
    assign hits_w = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count   <= '0;
            miss_count  <= '0;
            whiff_pulse <= 1'b0;
        end else if (!enable) begin
            hit_count   <= '0;
            miss_count  <= '0;
            whiff_pulse <= 1'b0;
        end else begin
            hit_count   <= CW'(popcount(POP_W'(hit_v)));
            miss_count  <= CW'(popcount(POP_W'(miss_v)));
            whiff_pulse <= |(hit_mask & ~mole_mask);
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed self-checking bench for mole_spawner.
// Honours MOLE_SPAWN_ACCEL_EN for the interval expectations.
module tb_mole_spawner;

    localparam int NH = 18;

`ifdef MOLE_SPAWN_ACCEL_EN
    localparam int GAP_LAST = 4;
`else
    localparam int GAP_LAST = 6;
`endif

    logic          clk;
    logic          reset;
    logic          enable;
    logic [4:0]    random_value;
    logic [NH-1:0] hit_mask;
    logic [NH-1:0] mole_mask;
    logic [4:0]    hit_count;
    logic [4:0]    miss_count;
    logic          whiff_pulse;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int msum = 0;
    int t_acc[5];

    // Up time long enough for two moles to overlap a spawn slot.
    mole_spawner #(
        .NUM_HOLES     (NH),
        .SPAWN_INTERVAL(5),
        .UP_TIME       (16),
        .MAX_ACTIVE    (2),
        .MAX_RETRY     (3),
        .ACCEL_STEP    (1),
        .MIN_INTERVAL  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .random_value(random_value),
        .hit_mask    (hit_mask),
        .mole_mask   (mole_mask),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .whiff_pulse (whiff_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Leaves the bench just after the first edge that sees enable high (cyc 0).
    task automatic restart(input logic [4:0] rv);
        enable       = 1'b0;
        hit_mask     = '0;
        random_value = rv;
        reset        = 1'b1;
        #1;
        chk("rst_mask", 32'(mole_mask), 32'h0);
        chk("rst_hit", 32'(hit_count), 32'h0);
        chk("rst_miss", 32'(miss_count), 32'h0);
        chk("rst_whiff", 32'(whiff_pulse), 32'h0);
        step(2);
        reset  = 1'b0;
        enable = 1'b1;
        cyc    = -1;
        step(1);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        random_value = '0;
        hit_mask     = '0;

        // first spawn, retries on occupied and out-of-range, expiry miss
        restart(5'd7);
        step(5);
        chk("spawn_early", 32'(mole_mask), 32'h0);
        step(1);
        chk("spawn_first", 32'(mole_mask), 32'h80);
        step(8);
        chk("busy_skip", 32'(mole_mask), 32'h80);
        random_value = 5'd4;
        step(1);
        chk("busy_no_4th", 32'(mole_mask), 32'h80);
        random_value = 5'd20;
        step(6);
        chk("up_last", 32'(mole_mask), 32'h80);
        chk("up_last_miss", 32'(miss_count), 32'h0);
        step(1);
        chk("expire_mask", 32'(mole_mask), 32'h0);
        chk("expire_miss", 32'(miss_count), 32'h1);
        random_value = 5'd4;
        step(1);
        chk("range_no_4th", 32'(mole_mask), 32'h0);
        chk("miss_one_cyc", 32'(miss_count), 32'h0);
        step(4);
        chk("reload_early", 32'(mole_mask), 32'h0);
        step(1);
        chk("reload_spawn", 32'(mole_mask), 32'h10);

        // single hit, no miss later
        restart(5'd7);
        step(6);
        random_value = 5'd20;
        hit_mask     = 18'h80;
        step(1);
        hit_mask = '0;
        chk("hit_mask", 32'(mole_mask), 32'h0);
        chk("hit_cnt", 32'(hit_count), 32'h1);
        chk("hit_miss", 32'(miss_count), 32'h0);
        chk("hit_whiff", 32'(whiff_pulse), 32'h0);
        msum = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            msum += int'(miss_count);
        end
        chk("hit_no_miss", 32'(msum), 32'h0);
        chk("hit_no_spawn", 32'(mole_mask), 32'h0);

        // full occupancy skips the slot at once
        restart(5'd2);
        step(6);
        chk("two_a", 32'(mole_mask), 32'h4);
        random_value = 5'd5;
        step(6);
        chk("two_b", 32'(mole_mask), 32'h24);
        random_value = 5'd9;
        step(6);
        chk("full_skip", 32'(mole_mask), 32'h24);
        step(4);
        chk("full_drop2", 32'(mole_mask), 32'h20);
        chk("full_drop2_miss", 32'(miss_count), 32'h1);
        step(1);
        chk("full_pick", 32'(mole_mask), 32'h20);
        step(1);
        chk("full_after", 32'(mole_mask), 32'h220);

        // double hit plus whiff
        restart(5'd2);
        step(6);
        random_value = 5'd5;
        step(6);
        chk("dbl_setup", 32'(mole_mask), 32'h24);
        random_value = 5'd20;
        hit_mask     = 18'h824;
        step(1);
        hit_mask = '0;
        chk("dbl_mask", 32'(mole_mask), 32'h0);
        chk("dbl_hit", 32'(hit_count), 32'h2);
        chk("dbl_whiff", 32'(whiff_pulse), 32'h1);
        chk("dbl_miss", 32'(miss_count), 32'h0);
        step(1);
        chk("dbl_hit_clr", 32'(hit_count), 32'h0);
        chk("dbl_whiff_clr", 32'(whiff_pulse), 32'h0);

        // hit on the last visible cycle wins over expiry
        restart(5'd2);
        step(6);
        random_value = 5'd20;
        step(15);
        chk("late_up", 32'(mole_mask), 32'h4);
        hit_mask = 18'h4;
        step(1);
        hit_mask = '0;
        chk("late_mask", 32'(mole_mask), 32'h0);
        chk("late_hit", 32'(hit_count), 32'h1);
        chk("late_miss", 32'(miss_count), 32'h0);
        step(1);
        chk("late_miss2", 32'(miss_count), 32'h0);

        // disable clears moles, ignores hits, reports nothing
        restart(5'd2);
        step(6);
        random_value = 5'd5;
        step(6);
        chk("dis_setup", 32'(mole_mask), 32'h24);
        enable   = 1'b0;
        hit_mask = 18'h4;
        step(1);
        hit_mask = '0;
        chk("dis_mask", 32'(mole_mask), 32'h0);
        chk("dis_hit", 32'(hit_count), 32'h0);
        chk("dis_miss", 32'(miss_count), 32'h0);
        chk("dis_whiff", 32'(whiff_pulse), 32'h0);
        enable = 1'b1;
        msum   = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            msum += int'(miss_count);
        end
        chk("ren_early", 32'(mole_mask), 32'h0);
        step(1);
        chk("ren_spawn", 32'(mole_mask), 32'h20);
        for (int i = 0; i < 4; i++) begin
            step(1);
            msum += int'(miss_count);
        end
        chk("ren_no_miss", 32'(msum), 32'h0);

        // spawn spacing as hits accumulate
        restart(5'd2);
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 20; n++) begin
                if (mole_mask != '0) break;
                step(1);
            end
            t_acc[k] = cyc;
            chk("acc_spawn", 32'(mole_mask), 32'h4);
            hit_mask = 18'h4;
            step(1);
            hit_mask = '0;
            chk("acc_hit", 32'(hit_count), 32'h1);
        end
        chk("acc_first", 32'(t_acc[0]), 32'd6);
        chk("acc_gap0", 32'(t_acc[1] - t_acc[0]), 32'd6);
        chk("acc_gap3", 32'(t_acc[4] - t_acc[3]), 32'(GAP_LAST));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
